// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with optional parity, 1-2 stop bits and a
// first-word-fall-through receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int OS     = 16,
  parameter int PARITY = 0,
  parameter int SBIT   = 1,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIV_W-1:0]         div,
  input  logic                     rx,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [DBIT-1:0]          dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int SC_W = $clog2(OS);
  localparam int NB_W = $clog2(DBIT);
  localparam int AW   = $clog2(DEPTH);

  localparam logic [SC_W-1:0] SC_HALF  = SC_W'(OS / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST  = SC_W'(OS - 1);
  localparam logic [NB_W-1:0] NB_DLAST = NB_W'(DBIT - 1);
  localparam logic [NB_W-1:0] NB_SLAST = NB_W'(SBIT - 1);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state;
  logic              rx_s1, rx_s2, rx_prev;
  logic [DIV_W-1:0]  tcnt;
  logic              tick;
  logic [SC_W-1:0]   sc;
  logic [NB_W-1:0]   nb;
  logic [DBIT-1:0]   shreg;
  logic              pbad;
  logic              ferr;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;

  logic bit_end, stop_done, frame_bad, push, do_pop, do_push;

  always_comb begin
    tick      = (tcnt == div);
    bit_end   = tick && (sc == SC_LAST);
    stop_done = (state == STOP) && bit_end && (nb == NB_SLAST);
    frame_bad = ferr | ~rx_s2;
    push      = stop_done & ~frame_bad;
    do_pop    = rd_en & ~empty;
    do_push   = push & (~full | do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      tcnt    <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      tcnt    <= tick ? '0 : tcnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sc    <= '0;
      nb    <= '0;
      shreg <= '0;
      pbad  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            state <= START;
            sc    <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (sc == SC_HALF) begin
              sc    <= '0;
              nb    <= '0;
              pbad  <= 1'b0;
              ferr  <= 1'b0;
              state <= rx_s2 ? IDLE : DATA;
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sc == SC_LAST) begin
              sc    <= '0;
              shreg <= {rx_s2, shreg[DBIT-1:1]};
              if (nb == NB_DLAST) begin
                nb    <= '0;
                state <= (PARITY != 0) ? PAR : STOP;
              end else begin
                nb <= nb + NB_W'(1);
              end
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
        end
        PAR: begin
          if (tick) begin
            if (sc == SC_LAST) begin
              sc    <= '0;
              state <= STOP;
              pbad  <= (PARITY == 1) ? ~(^shreg ^ rx_s2) : (^shreg ^ rx_s2);
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sc == SC_LAST) begin
              sc <= '0;
              if (!rx_s2) ferr <= 1'b1;
              if (nb == NB_SLAST) begin
                nb    <= '0;
                state <= IDLE;
              end else begin
                nb <= nb + NB_W'(1);
              end
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shreg;
  end

  // dout is a register so it can hold the last popped word while empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (do_pop) begin
        if (count > (AW + 1)'(1)) dout <= mem[rptr + AW'(1)];
        else if (do_push)         dout <= shreg;
      end else if (do_push && empty) begin
        dout <= shreg;
      end
    end
  end

  always_comb begin
    empty = (count == '0);
    full  = (count == CNT_FULL);
    level = count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (err_clr) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      if (push && pbad)               parity_err <= 1'b1;
      if (stop_done && frame_bad)     frame_err  <= 1'b1;
      if (push && full && !rd_en)     overrun    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1/depth-4 instance and an 8E2/depth-2 instance,
// driven with directed and random frames against a queue-based model.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div;
  logic        rx, rd_en, err_clr;
  logic        sel;

  always #5 clk = ~clk;

  logic [7:0] dout0, dout1;
  logic       empty0, empty1, full0, full1;
  logic [2:0] level0;
  logic [1:0] level1;
  logic       perr0, perr1, ferr0, ferr1, ovr0, ovr1;

  uart_rx_fifo u_dut (
    .clk(clk), .reset(reset), .div(div), .rx(sel ? 1'b1 : rx),
    .rd_en(rd_en & ~sel), .err_clr(err_clr & ~sel),
    .dout(dout0), .empty(empty0), .full(full0), .level(level0),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0)
  );

  uart_rx_fifo #(.PARITY(2), .SBIT(2), .DEPTH(2)) u_par (
    .clk(clk), .reset(reset), .div(div), .rx(sel ? rx : 1'b1),
    .rd_en(rd_en & sel), .err_clr(err_clr & sel),
    .dout(dout1), .empty(empty1), .full(full1), .level(level1),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1)
  );

  logic [7:0] dout_m;
  logic [2:0] level_m;
  logic       empty_m, full_m, perr_m, ferr_m, ovr_m;
  always_comb begin
    dout_m  = sel ? dout1 : dout0;
    level_m = sel ? {1'b0, level1} : level0;
    empty_m = sel ? empty1 : empty0;
    full_m  = sel ? full1 : full0;
    perr_m  = sel ? perr1 : perr0;
    ferr_m  = sel ? ferr1 : ferr0;
    ovr_m   = sel ? ovr1 : ovr0;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_last;
  bit         exp_par, exp_frm, exp_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int depth = sel ? 2 : 4;
    check({tag, "/level"}, 32'(level_m), 32'(exp_q.size()));
    check({tag, "/empty"}, 32'(empty_m), 32'(exp_q.size() == 0));
    check({tag, "/full"},  32'(full_m),  32'(exp_q.size() == depth));
    check({tag, "/dout"},  32'(dout_m),  32'(exp_q.size() != 0 ? exp_q[0] : exp_last));
    check({tag, "/perr"},  32'(perr_m),  32'(exp_par));
    check({tag, "/ferr"},  32'(ferr_m),  32'(exp_frm));
    check({tag, "/ovr"},   32'(ovr_m),   32'(exp_ovr));
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_last = '0;
    exp_par  = 1'b0;
    exp_frm  = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b1;
    rx      = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_state(tag);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Full frame plus one idle bit; the model is updated once the frame is over.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop_low);
    int b = (int'(div) + 1) * 16;
    int depth = sel ? 2 : 4;
    int nstop = sel ? 2 : 1;
    bit bad_par;
    drive_bit(1'b0, b);
    for (int i = 0; i < 8; i++) drive_bit(d[i], b);
    if (sel) drive_bit(^d ^ flip, b);
    for (int i = 0; i < nstop; i++) drive_bit(~stop_low, b);
    drive_bit(1'b1, b);
    bad_par = sel && flip;
    if (stop_low) begin
      exp_frm = 1'b1;
    end else begin
      if (bad_par) exp_par = 1'b1;
      if (exp_q.size() == depth) exp_ovr = 1'b1;
      else exp_q.push_back(d);
    end
  endtask

  task automatic pop(input string tag);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() != 0) exp_last = exp_q.pop_front();
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic clear_errs(input string tag);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_par = 1'b0;
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    sel = 1'b0;
    div = 16'd3;
    @(negedge clk);
    do_reset("reset0");

    pop("pop_empty");

    send_frame(8'hA5, 1'b0, 1'b0);
    check_state("a5");
    pop("a5_pop");

    send_frame(8'h3C, 1'b0, 1'b1);
    check_state("stop_low");
    clear_errs("clr_frm");

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_state("overrun");
    for (int i = 0; i < 4; i++) pop("drain");
    clear_errs("clr_ovr");

    rx = 1'b0;
    repeat ((16 / 2 - 2) * (int'(div) + 1)) @(negedge clk);
    rx = 1'b1;
    repeat (2 * 16 * (int'(div) + 1)) @(negedge clk);
    check_state("false_start");
    send_frame(8'h55, 1'b0, 1'b0);
    check_state("after_false");
    pop("x55_pop");

    // Abandon a 0x99 frame partway through its data bits
    drive_bit(1'b0, 64);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h99 >> i), 64);
    do_reset("reset_mid");
    send_frame(8'h66, 1'b0, 1'b0);
    check_state("x66");
    pop("x66_pop");

    div = 16'd1;
    for (int f = 0; f < 25; f++) begin
      send_frame(8'($urandom), 1'b0, $urandom_range(0, 7) == 0);
      check_state("rnd8n1");
      for (int r = $urandom_range(0, 2); r > 0; r--) pop("rnd8n1_pop");
      if ($urandom_range(0, 5) == 0) clear_errs("rnd8n1_clr");
    end

    sel = 1'b1;
    div = 16'd3;
    do_reset("reset_par");
    send_frame(8'h0F, 1'b1, 1'b0);
    check_state("par_bad");
    clear_errs("par_clr");
    send_frame(8'hC3, 1'b0, 1'b0);
    check_state("par_good");

    div = 16'd0;
    for (int f = 0; f < 25; f++) begin
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      check_state("rnd8e2");
      for (int r = $urandom_range(0, 2); r > 0; r--) pop("rnd8e2_pop");
      if ($urandom_range(0, 5) == 0) clear_errs("rnd8e2_clr");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
